// File: rtl/seq_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller: FSM encoding,
// slice width and the nibble-count helper.
package seq_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int unsigned NIBBLE = 4;

  function automatic int unsigned nibble_count(input int unsigned width);
    return width / NIBBLE;
  endfunction

endpackage

// File: rtl/seq_add_ctrl_rca4.sv
// RCA4: 4-bit ripple-carry adder slice shared by the serial adder controller.
module RCA4 (
  output logic [3:0] sum,
  output logic       carry,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = c0;
    for (int unsigned i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    carry = c[4];
  end

endmodule

// File: rtl/seq_add_ctrl.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a shared RCA4 slice,
// LSB nibble first. Define SEQ_ADD_SUB_EN to honour the sub input.
module seq_add_ctrl
  import seq_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N  = nibble_count(WIDTH);
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  if (((WIDTH % NIBBLE) != 0) || (WIDTH < 8)) begin : g_width_check
    $error("seq_add_ctrl: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t           state;
  state_t           state_next;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             cy;
  logic             a_msb;
  logic             b_msb;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [3:0]       slice_sum;
  logic             slice_cy;
  logic             accept;
  logic             step;
  logic             load;
  logic             ready_d;

`ifdef SEQ_ADD_SUB_EN
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub | cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_eff      = b;
  assign c_eff      = cin;
`endif

  RCA4 u_rca4 (
    .sum   (slice_sum),
    .carry (slice_cy),
    .a     (a_sr[3:0]),
    .b     (b_sr[3:0]),
    .c0    (cy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && ready) state_next = RUN;
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (k == K_LAST) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ready is a register: it drops on the accepting edge and stays low through
  // the cycle in which done is shown, so a new start can never overlap done.
  always_comb begin
    accept  = (state == IDLE) && ready && start;
    step    = (state == RUN) && !abort;
    load    = (state == DONE);
    ready_d = (state_next == IDLE) && (state != DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready  <= 1'b1;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      k      <= '0;
      cy     <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
    end else begin
      ready <= ready_d;
      done  <= load;
      if (accept) begin
        a_sr  <= a;
        b_sr  <= b_eff;
        cy    <= c_eff;
        k     <= '0;
        a_msb <= a[WIDTH-1];
        b_msb <= b_eff[WIDTH-1];
      end else if (step) begin
        a_sr   <= a_sr >> NIBBLE;
        b_sr   <= b_sr >> NIBBLE;
        res_sr <= {slice_sum, res_sr[WIDTH-1:NIBBLE]};
        cy     <= slice_cy;
        k      <= k + 1'b1;
      end
      if (load) begin
        sum  <= res_sr;
        cout <= cy;
        ovf  <= (a_msb == b_msb) && (res_sr[WIDTH-1] != a_msb);
      end
    end
  end

endmodule

// File: tb/tb_seq_add_ctrl.sv
// Directed bench for seq_add_ctrl at WIDTH=16; expectations follow
// SEQ_ADD_SUB_EN when the bench is compiled with it.
module tb_seq_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        ready;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

`ifdef SEQ_ADD_SUB_EN
  localparam logic [15:0] SUB_EXP = 16'hFFFE;
`else
  localparam logic [15:0] SUB_EXP = 16'h000C;
`endif

  seq_add_ctrl #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
    .ready (ready),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation from a negedge and follow it to completion.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                       input logic tsub, input logic tab,
                       output int lat, output int low, output logic [15:0] rs,
                       output logic rc, output logic ro, output logic d2);
    int w;
    w = 0;
    while (!ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", ready, 1'b1);
    a = ta; b = tb; cin = tcin; sub = tsub; abort = tab; start = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    lat = 0; low = 0;
    while (!done && lat < 20) begin
      if (!ready) low++;
      @(negedge clk);
      lat++;
    end
    if (!ready) low++;
    rs = sum; rc = cout; ro = ovf;
    @(negedge clk);
    d2 = done;
    w = 0;
    while (!ready && w < 10) begin
      low++;
      @(negedge clk);
      w++;
    end
  endtask

  initial begin
    int lat, low, nd;
    logic [15:0] rs;
    logic rc, ro, d2;
    logic [15:0] got [3];

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_done",  done,  1'b0);
    chk("rst_sum",   sum,   16'h0000);
    chk("rst_cout",  cout,  1'b0);
    chk("rst_ovf",   ovf,   1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain add with latency and handshake timing
    do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0, lat, low, rs, rc, ro, d2);
    chk("add_latency", lat, 5);
    chk("add_sum", rs, 16'h2233);
    chk("add_cout", rc, 1'b0);
    chk("add_ovf", ro, 1'b0);
    chk("add_done_pulse", d2, 1'b0);
    chk("add_ready_low", low, 6);

    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, lat, low, rs, rc, ro, d2);
    chk("wrap_sum", rs, 16'h0000);
    chk("wrap_cout", rc, 1'b1);
    chk("wrap_ovf", ro, 1'b0);

    // abort together with start in IDLE: start wins
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, lat, low, rs, rc, ro, d2);
    chk("ovf_latency", lat, 5);
    chk("ovf_sum", rs, 16'h8000);
    chk("ovf_cout", rc, 1'b0);
    chk("ovf_ovf", ro, 1'b1);

    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, lat, low, rs, rc, ro, d2);
    chk("sub_sum", rs, SUB_EXP);
    chk("sub_cout", rc, 1'b0);
    chk("sub_ovf", ro, 1'b0);

    do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0, lat, low, rs, rc, ro, d2);
    chk("prior_sum", rs, 16'h2233);

    // Abort in the second RUN cycle
    a = 16'h1111; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_ready", ready, 1'b1);
    chk("abort_done", done, 1'b0);
    chk("abort_sum", sum, 16'h2233);
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    chk("abort_sum_held", sum, 16'h2233);
    do_op(16'h1111, 16'h1111, 1'b0, 1'b0, 1'b0, lat, low, rs, rc, ro, d2);
    chk("post_abort_latency", lat, 5);
    chk("post_abort_sum", rs, 16'h2222);

    // start held every cycle: accepts land at offsets 0, 7 and 14
    nd = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) begin
        if (nd < 3) got[nd] = sum;
        nd++;
      end
      start = (i <= 14);
      a = 16'(16'h1000 + i);
      b = 16'(16'h0010 * i);
      @(negedge clk);
    end
    start = 1'b0;
    chk("hs_done_count", nd, 3);
    chk("hs_sum0", got[0], 16'h1000);
    chk("hs_sum1", got[1], 16'h1077);
    chk("hs_sum2", got[2], 16'h10EE);

    // Reset in the third RUN cycle
    repeat (3) @(negedge clk);
    a = 16'h1234; b = 16'h0FFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ready, 1'b1);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_sum", sum, 16'h0000);
    chk("mid_rst_cout", cout, 1'b0);
    chk("mid_rst_ovf", ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, lat, low, rs, rc, ro, d2);
    chk("post_rst_latency", lat, 5);
    chk("post_rst_sum", rs, 16'h0000);
    chk("post_rst_cout", rc, 1'b1);
    chk("post_rst_ovf", ro, 1'b1);
    do_op(16'h1234, 16'h0FFF, 1'b1, 1'b0, 1'b0, lat, low, rs, rc, ro, d2);
    chk("cin_sum", rs, 16'h2234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
